// File: rtl/apb_bridge_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_bridge_ctrl_if
// Brief    : AHB-side request and APB-side bus bundle for the bridge controller
// Revision : 1.0
// ============================================================================
interface apb_bridge_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSLV   = 3
);
    logic              valid;
    logic              Hwrite;
    logic [ADDR_W-1:0] Haddr;
    logic [DATA_W-1:0] Hwdata;
    logic [NSLV-1:0]   tempselx;
    logic [DATA_W-1:0] Prdata;
    logic              Pready;
    logic              Pslverr;

    logic [ADDR_W-1:0] Paddr;
    logic [DATA_W-1:0] Pwdata;
    logic              Pwrite;
    logic [NSLV-1:0]   Pselx;
    logic              Penable;
    logic              Hreadyout;
    logic              Hresp;
    logic [DATA_W-1:0] Hrdata;
    logic [2:0]        CS;

    modport slave (
        input  valid, Hwrite, Haddr, Hwdata, tempselx, Prdata, Pready, Pslverr,
        output Paddr, Pwdata, Pwrite, Pselx, Penable, Hreadyout, Hresp, Hrdata, CS
    );

    modport master (
        output valid, Hwrite, Haddr, Hwdata, tempselx, Prdata, Pready, Pslverr,
        input  Paddr, Pwdata, Pwrite, Pselx, Penable, Hreadyout, Hresp, Hrdata, CS
    );
endinterface
`default_nettype wire

// File: rtl/apb_bridge_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : apb_bridge_ctrl
// Brief    : AHB-to-APB bridge FSM with decode/slave-error and ACCESS timeout
// Revision : 1.0
// ============================================================================
module apb_bridge_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NSLV    = 3,
    parameter int TIMEOUT = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    apb_bridge_ctrl_if.slave   bus
);

    localparam int                 c_cnt_w       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_timeout_cnt = c_cnt_w'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        WWAIT  = 3'b001,
        SETUP  = 3'b010,
        ACCESS = 3'b011,
        ERR1   = 3'b100,
        ERR2   = 3'b101
    } state_t;

    state_t              cs_q,        cs_d;
    logic [ADDR_W-1:0]   haddr_h_q,   haddr_h_d;
    logic                hwrite_h_q,  hwrite_h_d;
    logic [NSLV-1:0]     sel_h_q,     sel_h_d;
    logic [ADDR_W-1:0]   paddr_q,     paddr_d;
    logic [DATA_W-1:0]   pwdata_q,    pwdata_d;
    logic                pwrite_q,    pwrite_d;
    logic [NSLV-1:0]     pselx_q,     pselx_d;
    logic                penable_q,   penable_d;
    logic                hreadyout_q, hreadyout_d;
    logic                hresp_q,     hresp_d;
    logic [DATA_W-1:0]   hrdata_q,    hrdata_d;
    logic [c_cnt_w-1:0]  wait_cnt_q,  wait_cnt_d;

    logic w_sel_onehot;
    logic w_timeout;

    assign w_sel_onehot = (bus.tempselx != '0) &&
                          ((bus.tempselx & (bus.tempselx - NSLV'(1))) == '0);
    assign w_timeout    = (TIMEOUT > 0) && (wait_cnt_q == c_timeout_cnt);

    always_comb begin
        cs_d       = cs_q;
        haddr_h_d  = haddr_h_q;
        hwrite_h_d = hwrite_h_q;
        sel_h_d    = sel_h_q;
        pwdata_d   = pwdata_q;
        hrdata_d   = hrdata_q;
        wait_cnt_d = wait_cnt_q;

        case (cs_q)
            IDLE: begin
                if (bus.valid) begin
                    haddr_h_d  = bus.Haddr;
                    hwrite_h_d = bus.Hwrite;
                    sel_h_d    = bus.tempselx;
                    if (!w_sel_onehot)   cs_d = ERR1;
                    else if (bus.Hwrite) cs_d = WWAIT;
                    else                 cs_d = SETUP;
                end
            end
            WWAIT: begin
                pwdata_d = bus.Hwdata;
                cs_d     = SETUP;
            end
            SETUP: cs_d = ACCESS;
            ACCESS: begin
                if (bus.Pready) begin
                    if (bus.Pslverr) begin
                        cs_d = ERR1;
                    end else begin
                        cs_d = IDLE;
                        if (!hwrite_h_q) hrdata_d = bus.Prdata;
                    end
                end else if (w_timeout) begin
                    cs_d = ERR1;
                end else begin
                    wait_cnt_d = wait_cnt_q + c_cnt_w'(1);
                end
            end
            ERR1:    cs_d = ERR2;
            ERR2:    cs_d = IDLE;
            default: cs_d = IDLE;
        endcase

        if (cs_d == SETUP) wait_cnt_d = '0;

        // Outputs are decoded from the next state so they register alongside it.
        paddr_d     = (cs_d == SETUP) ? haddr_h_d  : paddr_q;
        pwrite_d    = (cs_d == SETUP) ? hwrite_h_d : pwrite_q;
        pselx_d     = (cs_d == SETUP || cs_d == ACCESS) ? sel_h_d : '0;
        penable_d   = (cs_d == ACCESS);
        hreadyout_d = (cs_d == IDLE) || (cs_d == ERR2);
        hresp_d     = (cs_d == ERR1) || (cs_d == ERR2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_q        <= IDLE;
            haddr_h_q   <= '0;
            hwrite_h_q  <= 1'b0;
            sel_h_q     <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            pselx_q     <= '0;
            penable_q   <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
            wait_cnt_q  <= '0;
        end else begin
            cs_q        <= cs_d;
            haddr_h_q   <= haddr_h_d;
            hwrite_h_q  <= hwrite_h_d;
            sel_h_q     <= sel_h_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            pselx_q     <= pselx_d;
            penable_q   <= penable_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign bus.Paddr     = paddr_q;
    assign bus.Pwdata    = pwdata_q;
    assign bus.Pwrite    = pwrite_q;
    assign bus.Pselx     = pselx_q;
    assign bus.Penable   = penable_q;
    assign bus.Hreadyout = hreadyout_q;
    assign bus.Hresp     = hresp_q;
    assign bus.Hrdata    = hrdata_q;
    assign bus.CS        = cs_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_bridge_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_bridge_ctrl
// Brief    : Self-checking bench; per-transaction cycle traces from a model
// Revision : 1.0
// ============================================================================
module tb_apb_bridge_ctrl;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int NSLV    = 3;
    localparam int TIMEOUT = 4;

    localparam logic [2:0] S_IDLE   = 3'b000;
    localparam logic [2:0] S_WWAIT  = 3'b001;
    localparam logic [2:0] S_SETUP  = 3'b010;
    localparam logic [2:0] S_ACCESS = 3'b011;
    localparam logic [2:0] S_ERR1   = 3'b100;
    localparam logic [2:0] S_ERR2   = 3'b101;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    apb_bridge_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSLV(NSLV)) bus ();

    apb_bridge_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .NSLV   (NSLV),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    // Values the APB side should be showing / have returned, per transaction history.
    logic [ADDR_W-1:0] m_paddr;
    logic [DATA_W-1:0] m_pwdata;
    logic [DATA_W-1:0] m_hrdata;
    logic              m_pwrite;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle(input logic [2:0] st, input logic [2:0] sel, input string ctx);
        check({ctx, ":CS"},        64'(bus.CS),        64'(st));
        check({ctx, ":Hreadyout"}, 64'(bus.Hreadyout), 64'(st == S_IDLE || st == S_ERR2));
        check({ctx, ":Hresp"},     64'(bus.Hresp),     64'(st == S_ERR1 || st == S_ERR2));
        check({ctx, ":Penable"},   64'(bus.Penable),   64'(st == S_ACCESS));
        check({ctx, ":Pselx"},     64'(bus.Pselx),
              64'((st == S_SETUP || st == S_ACCESS) ? sel : 3'b000));
        check({ctx, ":Paddr"},     64'(bus.Paddr),     64'(m_paddr));
        check({ctx, ":Pwrite"},    64'(bus.Pwrite),    64'(m_pwrite));
        check({ctx, ":Pwdata"},    64'(bus.Pwdata),    64'(m_pwdata));
        check({ctx, ":Hrdata"},    64'(bus.Hrdata),    64'(m_hrdata));
    endtask

    // One AHB transfer starting in an IDLE cycle; ends after checking the closing IDLE cycle.
    task automatic txn(input logic wr, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata, input logic [2:0] sel,
                       input int nwait, input logic slverr,
                       input logic [DATA_W-1:0] rdata, input string name);
        logic [2:0] trace[$];
        bit onehot, aborted, err;
        int acc, k;
        onehot  = (sel == 3'b001) || (sel == 3'b010) || (sel == 3'b100);
        aborted = nwait > TIMEOUT;
        acc     = aborted ? TIMEOUT + 1 : nwait + 1;
        err     = !onehot || aborted || slverr;
        if (onehot) begin
            if (wr) trace.push_back(S_WWAIT);
            trace.push_back(S_SETUP);
            repeat (acc) trace.push_back(S_ACCESS);
        end
        if (err) begin
            trace.push_back(S_ERR1);
            trace.push_back(S_ERR2);
        end
        trace.push_back(S_IDLE);

        bus.valid    = 1'b1;
        bus.Hwrite   = wr;
        bus.Haddr    = addr;
        bus.tempselx = sel;
        bus.Hwdata   = DATA_W'($urandom);
        bus.Pready   = 1'($urandom);
        bus.Pslverr  = 1'($urandom);
        bus.Prdata   = DATA_W'($urandom);
        k = 0;
        for (int i = 0; i < trace.size(); i++) begin
            @(posedge clk);
            #1;
            if (trace[i] == S_SETUP) begin
                m_paddr  = addr;
                m_pwrite = wr;
                if (wr) m_pwdata = wdata;
            end
            if (i == trace.size() - 1 && !err && !wr) m_hrdata = rdata;
            check_cycle(trace[i], sel, $sformatf("%s[%0d]", name, i));

            // Junk on every input the bridge should be ignoring right now.
            bus.valid    = (i == trace.size() - 1) ? 1'b0 : 1'($urandom);
            bus.Hwrite   = 1'($urandom);
            bus.Haddr    = ADDR_W'($urandom);
            bus.tempselx = 3'($urandom);
            bus.Hwdata   = (trace[i] == S_WWAIT) ? wdata : DATA_W'($urandom);
            if (trace[i] == S_ACCESS) begin
                bus.Pready  = (k == nwait);
                bus.Pslverr = (k == nwait) ? slverr : 1'($urandom);
                bus.Prdata  = (k == nwait) ? rdata  : DATA_W'($urandom);
                k++;
            end else begin
                bus.Pready  = 1'($urandom);
                bus.Pslverr = 1'($urandom);
                bus.Prdata  = DATA_W'($urandom);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [2:0] sel;
        int         r;
        rst          = 1'b1;
        bus.valid    = 1'b0;
        bus.Hwrite   = 1'b0;
        bus.Haddr    = '0;
        bus.Hwdata   = '0;
        bus.tempselx = '0;
        bus.Prdata   = '0;
        bus.Pready   = 1'b0;
        bus.Pslverr  = 1'b0;
        m_paddr = '0; m_pwdata = '0; m_hrdata = '0; m_pwrite = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        bus.valid = 1'b1;
        bus.tempselx = 3'b001;
        @(posedge clk);
        #1;
        check_cycle(S_IDLE, 3'b001, "reset_hold");
        bus.valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        txn(1'b0, 32'h100, 32'h0, 3'b001, 0, 1'b0, 32'hA5A5, "read");
        txn(1'b1, 32'h204, 32'h55, 3'b010, 3, 1'b0, 32'h0, "write_wait");
        txn(1'b0, 32'h308, 32'h0, 3'b100, 1, 1'b1, 32'hDEAD, "slverr");
        txn(1'b0, 32'h40C, 32'h0, 3'b000, 0, 1'b0, 32'h0, "dec_000");
        txn(1'b1, 32'h510, 32'h77, 3'b011, 0, 1'b0, 32'h0, "dec_011");
        txn(1'b0, 32'h614, 32'h0, 3'b001, 1000, 1'b0, 32'h1234, "timeout_stuck");
        txn(1'b0, 32'h718, 32'h0, 3'b010, TIMEOUT, 1'b0, 32'h5678, "timeout_win");
        txn(1'b1, 32'h81C, 32'h99, 3'b100, TIMEOUT + 1, 1'b0, 32'h0, "wr_timeout");

        // Asynchronous reset in the middle of ACCESS.
        bus.valid = 1'b1; bus.Hwrite = 1'b0; bus.Haddr = 32'h920; bus.tempselx = 3'b010;
        bus.Pready = 1'b0;
        @(posedge clk); #1;
        m_paddr = 32'h920; m_pwrite = 1'b0;
        check_cycle(S_SETUP, 3'b010, "rst_setup");
        bus.valid = 1'b0;
        @(posedge clk); #1;
        check_cycle(S_ACCESS, 3'b010, "rst_access");
        #2;
        rst = 1'b1;
        #1;
        m_paddr = '0; m_pwdata = '0; m_hrdata = '0; m_pwrite = 1'b0;
        check_cycle(S_IDLE, 3'b010, "rst_async");
        @(negedge clk);
        rst = 1'b0;
        txn(1'b0, 32'hA24, 32'h0, 3'b100, 2, 1'b0, 32'hCAFE, "post_rst_read");

        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7) sel = 3'b001 << $urandom_range(0, 2);
            else       sel = 3'($urandom);
            txn(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom), sel,
                int'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0),
                DATA_W'($urandom), $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
